irq_request_controller: RTL and testbench

- Sequential front end of the 4-bit priority encoder.
- Captures four interrupt request lines into sticky pending bits and applies a per-line mask.
- Feeds the masked vector to the encoder, then raises a registered interrupt carrying the winning ID.
- Holds that interrupt under a four-phase ack handshake until the consumer acknowledges, then clears only the serviced line.

---
 rtl/irq_ctrl_defs.vh | 7 +
 rtl/priority_encoder_gate.sv | 17 +
 rtl/irq_request_controller.sv | 118 +++++++++++
 tb/tb_irq_request_controller.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_defs.vh
// rtl/irq_ctrl_defs.vh - shared FSM state encodings for the interrupt request controller
`ifndef IRQ_CTRL_DEFS_VH
`define IRQ_CTRL_DEFS_VH
localparam logic [1:0] IRQ_ST_IDLE      = 2'd0;
localparam logic [1:0] IRQ_ST_ASSERT    = 2'd1;
localparam logic [1:0] IRQ_ST_WAIT_DROP = 2'd2;
`endif

// File: rtl/priority_encoder_gate.sv
// rtl/priority_encoder_gate.sv - gate-level 4-bit priority encoder, d[3] highest
module priority_encoder_gate (
  input  logic [3:0] d,
  output logic       valid,
  output logic [1:0] c
);

  logic d2_n;
  logic d1_only;

  or  g_valid (valid, d[3], d[2], d[1], d[0]);
  or  g_c1    (c[1], d[3], d[2]);
  not g_d2n   (d2_n, d[2]);
  and g_d1    (d1_only, d2_n, d[1]);
  or  g_c0    (c[0], d[3], d1_only);

endmodule

// File: rtl/irq_request_controller.sv
// rtl/irq_request_controller.sv - sticky request capture, masking and four-phase irq handshake
module irq_request_controller #(
  parameter bit EDGE_DETECT = 1'b1,
  parameter int NUM_REQ     = 4
) (
  input  logic               clock,
  input  logic               reset_b,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] mask,
  input  logic               ack,
  output logic               irq,
  output logic [1:0]         irq_id,
  output logic [NUM_REQ-1:0] pending,
  output logic               busy
);

  `include "irq_ctrl_defs.vh"

  typedef enum logic [1:0] {
    S_IDLE      = IRQ_ST_IDLE,
    S_ASSERT    = IRQ_ST_ASSERT,
    S_WAIT_DROP = IRQ_ST_WAIT_DROP
  } state_e;

  state_e             state_q;
  logic               irq_q;
  logic [1:0]         irq_id_q;
  logic               busy_q;
  logic [NUM_REQ-1:0] pending_q, pending_d;
  logic [NUM_REQ-1:0] req_q;
  logic               armed_q;
  logic [NUM_REQ-1:0] set_vec, clr_vec, masked;
  logic               enc_valid;
  logic [1:0]         enc_code;

  // armed_q blocks the first post-reset edge so lines already high at release are not seen as new edges
  generate
    if (EDGE_DETECT) begin : g_edge
      assign set_vec = req & ~req_q & {NUM_REQ{armed_q}};
    end else begin : g_level
      assign set_vec = req;
    end
  endgenerate

  always_comb begin
    clr_vec = '0;
    if (state_q == S_ASSERT && ack) begin
      clr_vec[irq_id_q] = 1'b1;
    end
  end

  // set is OR'd after the clear so a same-cycle re-request survives service
  assign pending_d = (pending_q & ~clr_vec) | set_vec;
  assign masked    = pending_q & mask;

  priority_encoder_gate u_enc (
    .d     (masked),
    .valid (enc_valid),
    .c     (enc_code)
  );

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      pending_q <= '0;
      req_q     <= '0;
      armed_q   <= 1'b0;
    end else begin
      pending_q <= pending_d;
      req_q     <= req;
      armed_q   <= 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q  <= S_IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= 2'd0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enc_valid) begin
            state_q  <= S_ASSERT;
            irq_q    <= 1'b1;
            irq_id_q <= enc_code;
            busy_q   <= 1'b1;
          end else begin
            irq_q <= 1'b0;
          end
        end
        S_ASSERT: begin
          if (ack) begin
            state_q <= S_WAIT_DROP;
            irq_q   <= 1'b0;
          end
        end
        S_WAIT_DROP: begin
          if (!ack) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          irq_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign irq     = irq_q;
  assign irq_id  = irq_id_q;
  assign pending = pending_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_irq_request_controller.sv
// tb/tb_irq_request_controller.sv - table-driven scoreboard bench for irq_request_controller
module tb_irq_request_controller;

  logic       clock;
  logic       reset_b;
  logic [3:0] req;
  logic [3:0] mask;
  logic       ack;
  logic       irq;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic       busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] mask;
    logic       ack;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;
  } vec_t;

  typedef struct {
    int         row;
    logic       irq;
    logic [1:0] id;
    logic [3:0] pend;
    logic       busy;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  irq_request_controller #(.EDGE_DETECT(1'b1), .NUM_REQ(4)) dut (
    .clock   (clock),
    .reset_b (reset_b),
    .req     (req),
    .mask    (mask),
    .ack     (ack),
    .irq     (irq),
    .irq_id  (irq_id),
    .pending (pending),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input int row, input logic [3:0] got, input logic [3:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", name, row, got, want);
    end
  endtask

  task automatic add(input logic [3:0] r, input logic [3:0] m, input logic a,
                     input logic i, input logic [1:0] id, input logic [3:0] p, input logic b);
    vec_t v;
    v.req = r; v.mask = m; v.ack = a; v.irq = i; v.id = id; v.pend = p; v.busy = b;
    vecs.push_back(v);
  endtask

  task automatic compare_outputs(input exp_t e);
    check("irq",     e.row, {3'b0, irq},  {3'b0, e.irq});
    check("irq_id",  e.row, {2'b0, irq_id}, {2'b0, e.id});
    check("pending", e.row, pending,      e.pend);
    check("busy",    e.row, {3'b0, busy}, {3'b0, e.busy});
  endtask

  initial begin
    exp_t e;
    reset_b = 1'b0;
    req     = 4'b1111;
    mask    = 4'b1111;
    ack     = 1'b0;

    // req  mask  ack | irq id pending busy  (outputs after the edge)
    add(4'b1111, 4'b1111, 0, 0, 2'd0, 4'b0000, 0);  // held-high req at release: no edge
    add(4'b1111, 4'b1111, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0000, 4'b1111, 0, 0, 2'd0, 4'b0000, 0);
    add(4'b0100, 4'b1111, 0, 0, 2'd0, 4'b0100, 0);  // single pulse on line 2
    add(4'b0000, 4'b1111, 0, 1, 2'd2, 4'b0100, 1);
    add(4'b0000, 4'b1111, 0, 1, 2'd2, 4'b0100, 1);
    add(4'b0000, 4'b1111, 1, 0, 2'd2, 4'b0000, 1);
    add(4'b0000, 4'b1111, 0, 0, 2'd2, 4'b0000, 0);
    add(4'b0011, 4'b1111, 0, 0, 2'd2, 4'b0011, 0);  // two lines together
    add(4'b0000, 4'b1111, 0, 1, 2'd1, 4'b0011, 1);
    add(4'b0000, 4'b1111, 1, 0, 2'd1, 4'b0001, 1);
    add(4'b0000, 4'b1111, 0, 0, 2'd1, 4'b0001, 0);
    add(4'b0000, 4'b1111, 0, 1, 2'd0, 4'b0001, 1);
    add(4'b1000, 4'b1111, 0, 1, 2'd0, 4'b1001, 1);  // no preemption by line 3
    add(4'b0000, 4'b1111, 0, 1, 2'd0, 4'b1001, 1);
    add(4'b0000, 4'b1111, 1, 0, 2'd0, 4'b1000, 1);
    add(4'b0000, 4'b1111, 0, 0, 2'd0, 4'b1000, 0);
    add(4'b0000, 4'b1111, 0, 1, 2'd3, 4'b1000, 1);
    add(4'b0000, 4'b1111, 1, 0, 2'd3, 4'b0000, 1);
    add(4'b0000, 4'b1111, 0, 0, 2'd3, 4'b0000, 0);
    add(4'b1000, 4'b0111, 0, 0, 2'd3, 4'b1000, 0);  // masked line stays pending
    add(4'b0000, 4'b0111, 0, 0, 2'd3, 4'b1000, 0);
    add(4'b0000, 4'b0111, 0, 0, 2'd3, 4'b1000, 0);
    add(4'b0000, 4'b1111, 0, 1, 2'd3, 4'b1000, 1);
    add(4'b0000, 4'b1111, 1, 0, 2'd3, 4'b0000, 1);
    add(4'b0000, 4'b1111, 0, 0, 2'd3, 4'b0000, 0);
    add(4'b0010, 4'b1111, 0, 0, 2'd3, 4'b0010, 0);  // re-request in the ack cycle
    add(4'b0000, 4'b1111, 0, 1, 2'd1, 4'b0010, 1);
    add(4'b0010, 4'b1111, 1, 0, 2'd1, 4'b0010, 1);
    add(4'b0000, 4'b1111, 0, 0, 2'd1, 4'b0010, 0);
    add(4'b0000, 4'b1111, 0, 1, 2'd1, 4'b0010, 1);

    @(posedge clock);
    #1;
    e.row = -1; e.irq = 1'b0; e.id = 2'd0; e.pend = 4'b0000; e.busy = 1'b0;
    compare_outputs(e);
    reset_b = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      req  = vecs[i].req;
      mask = vecs[i].mask;
      ack  = vecs[i].ack;
      e.row = i; e.irq = vecs[i].irq; e.id = vecs[i].id; e.pend = vecs[i].pend; e.busy = vecs[i].busy;
      sb.push_back(e);
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("FAIL scoreboard row %0d: got empty queue want 1 entry", i);
      end else begin
        compare_outputs(sb.pop_front());
      end
    end

    // asynchronous reset while ASSERT with a pending line
    req = 4'b0000;
    #2;
    reset_b = 1'b0;
    #1;
    e.row = 99; e.irq = 1'b0; e.id = 2'd0; e.pend = 4'b0000; e.busy = 1'b0;
    compare_outputs(e);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
